// File: rtl/gzip_regs_pkg.sv
// Shared constants for the gzip control/status register bank: byte address
// map, CTRL/STATUS bit positions and btype encodings.
package gzip_regs_pkg;

  // Byte address map
  localparam logic [31:0] A_ID     = 32'd0;
  localparam logic [31:0] A_NCH    = 32'd1;
  localparam logic [31:0] A_GCTRL  = 32'd2;
  localparam logic [31:0] A_CHSEL  = 32'd3;
  localparam logic [31:0] A_CTRL   = 32'd4;
  localparam logic [31:0] A_CMD    = 32'd5;
  localparam logic [31:0] A_STATUS = 32'd6;
  localparam logic [31:0] A_SNAP   = 32'd8;

  // CTRL register bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_BT_LO = 1;
  localparam int CTRL_BT_HI = 2;
  localparam int CTRL_REV   = 3;

  // CMD register bit positions
  localparam int CMD_RST  = 0;
  localparam int CMD_SNAP = 1;

  // STATUS register bit positions
  localparam int STATUS_RST  = 0;
  localparam int STATUS_BUSY = 1;

  // Deflate block types; 2'b1x is reserved and never stored
  localparam logic [1:0] BTYPE_STORED = 2'b00;
  localparam logic [1:0] BTYPE_FIXED  = 2'b01;

endpackage

// File: rtl/gzip_ctrl_regs_if.sv
// Byte-wide auto-incrementing register access bus.
// Handshake: there is no valid/ready pair. mem_addr_update, mem_rden and
// mem_wren are single-cycle strobes sampled at each rising clk edge. The
// slave always accepts them; mem_rd_data shows the byte at the current
// pointer with zero latency and is valid whenever mem_rd_empty is 0.
// Asserting mem_rden consumes that byte (pointer advances at the edge).
interface gzip_ctrl_regs_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_addr_update;
  logic                  mem_rden;
  logic [7:0]            mem_rd_data;
  logic                  mem_rd_empty;
  logic                  mem_wren;
  logic [7:0]            mem_wr_data;

  // Host side
  modport master (
    output mem_addr, mem_addr_update, mem_rden, mem_wren, mem_wr_data,
    input  mem_rd_data, mem_rd_empty
  );

  // Register bank side
  modport slave (
    input  mem_addr, mem_addr_update, mem_rden, mem_wren, mem_wr_data,
    output mem_rd_data, mem_rd_empty
  );
endinterface

// File: rtl/gzip_ch_rst_pulse.sv
// Per-channel soft-reset pulse timer with registered reset output.
// ch_rst_o is computed from the next counter value so it rises on the
// edge that accepts the start command and stays high RST_PULSE_CYCLES
// cycles. hold_i (global hold or channel disabled) forces it high.
module gzip_ch_rst_pulse #(
  parameter int RST_PULSE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic hold_i,
  output logic ch_rst_o
);

  localparam int CW = $clog2(RST_PULSE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ch_rst_q;

  // Counter next state: a start (re)loads, otherwise count down to zero
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = CW'(RST_PULSE_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter and registered channel reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      ch_rst_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      ch_rst_q <= hold_i | (cnt_d != '0);
    end
  end

  assign ch_rst_o = ch_rst_q;

endmodule

// File: rtl/gzip_ctrl_regs.sv
// Multi-channel control/status register bank for NUM_CH Deflate cores.
// Byte-wide auto-incrementing register port, per-channel reset/btype/
// endianness controls, timed soft-reset pulses and debug-bus snapshots.
// Optional build macro GZIP_REGS_AUTO_SNAP_EN: loading the pointer with
// the first snapshot address also captures ch_dbg of the selected channel.
module gzip_ctrl_regs
  import gzip_regs_pkg::*;
#(
  parameter int         NUM_CH           = 2,
  parameter int         DBG_WIDTH        = 96,
  parameter int         ADDR_WIDTH       = 5,
  parameter int         RST_PULSE_CYCLES = 16,
  parameter logic [7:0] DEVICE_ID        = 8'hB9
) (
  input  logic                        clk,
  input  logic                        rst,
  gzip_ctrl_regs_if.slave             bus,
  input  logic [NUM_CH-1:0]           ch_busy,
  input  logic [DBG_WIDTH*NUM_CH-1:0] ch_dbg,
  output logic [NUM_CH-1:0]           ch_rst,
  output logic [2*NUM_CH-1:0]         ch_btype,
  output logic [NUM_CH-1:0]           ch_rev_endianess
);

  localparam int SNAP_BYTES = DBG_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]     ptr_q, ptr_d;
  logic                      gctrl_q, gctrl_d;
  logic [2:0]                chsel_q, chsel_d;
  logic [NUM_CH-1:0]         en_q, en_d;
  logic [NUM_CH-1:0]         rev_q, rev_d;
  logic [NUM_CH-1:0][1:0]    btype_q, btype_d;
  logic [DBG_WIDTH-1:0]      snap_q [NUM_CH];
  logic [NUM_CH-1:0]         sel_oh;
  logic [NUM_CH-1:0]         start;
  logic [NUM_CH-1:0]         cap;
  logic [31:0]               acc_addr;
  logic [7:0]                rd_byte;
  logic                      sel_en, sel_rev, sel_rst, sel_busy;
  logic [1:0]                sel_bt;
  logic [DBG_WIDTH-1:0]      sel_snap;

  assign acc_addr = 32'(ptr_q);

  // One-hot decode of the selected channel
  always_comb begin
    sel_oh = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_oh[c] = (chsel_q == 3'(c));
    end
  end

  // Read mux: byte at the pointer, built from registered state only
  always_comb begin
    rd_byte  = '0;
    sel_en   = 1'b0;
    sel_rev  = 1'b0;
    sel_rst  = 1'b0;
    sel_busy = 1'b0;
    sel_bt   = '0;
    sel_snap = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_oh[c]) begin
        sel_en   = en_q[c];
        sel_rev  = rev_q[c];
        sel_rst  = ch_rst[c];
        sel_busy = ch_busy[c];
        sel_bt   = btype_q[c];
        sel_snap = snap_q[c];
      end
    end
    case (acc_addr)
      A_ID:    rd_byte = DEVICE_ID;
      A_NCH:   rd_byte = 8'(NUM_CH);
      A_GCTRL: rd_byte = {7'd0, gctrl_q};
      A_CHSEL: rd_byte = {5'd0, chsel_q};
      A_CTRL: begin
        rd_byte[CTRL_EN]           = sel_en;
        rd_byte[CTRL_BT_LO +: 2]   = sel_bt;
        rd_byte[CTRL_REV]          = sel_rev;
      end
      A_STATUS: begin
        rd_byte[STATUS_RST]  = sel_rst;
        rd_byte[STATUS_BUSY] = sel_busy;
      end
      default: begin
        for (int b = 0; b < SNAP_BYTES; b++) begin
          if (acc_addr == A_SNAP + 32'(b)) begin
            rd_byte = sel_snap[8*b +: 8];
          end
        end
      end
    endcase
  end

  assign bus.mem_rd_data  = rd_byte;
  assign bus.mem_rd_empty = rst;

  // Write decode at the current pointer, plus pointer advance
  always_comb begin
    gctrl_d = gctrl_q;
    chsel_d = chsel_q;
    en_d    = en_q;
    rev_d   = rev_q;
    btype_d = btype_q;
    start   = '0;
    cap     = '0;
    if (bus.mem_wren) begin
      case (acc_addr)
        A_GCTRL: gctrl_d = bus.mem_wr_data[0];
        A_CHSEL: begin
          if (32'(bus.mem_wr_data) < NUM_CH) begin
            chsel_d = bus.mem_wr_data[2:0];
          end
        end
        A_CTRL: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (sel_oh[c]) begin
              en_d[c]  = bus.mem_wr_data[CTRL_EN];
              rev_d[c] = bus.mem_wr_data[CTRL_REV];
              // Reserved 2'b1x encodings leave the stored btype alone
              if (!bus.mem_wr_data[CTRL_BT_HI]) begin
                btype_d[c] = bus.mem_wr_data[CTRL_BT_LO +: 2];
              end
            end
          end
        end
        A_CMD: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (sel_oh[c]) begin
              start[c] = bus.mem_wr_data[CMD_RST];
              cap[c]   = bus.mem_wr_data[CMD_SNAP];
            end
          end
        end
        default: ;
      endcase
    end
`ifdef GZIP_REGS_AUTO_SNAP_EN
    // Loading the pointer onto the snapshot window refreshes the snapshot
    // of the channel selected before any same-cycle CH_SEL write lands
    if (bus.mem_addr_update && (32'(bus.mem_addr) == A_SNAP)) begin
      cap = cap | sel_oh;
    end
`endif
    // Access uses the old pointer; an update then overrides the increment
    if (bus.mem_addr_update) begin
      ptr_d = bus.mem_addr;
    end else if (bus.mem_rden || bus.mem_wren) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Register state and debug snapshots
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      gctrl_q <= 1'b0;
      chsel_q <= '0;
      en_q    <= '0;
      rev_q   <= '0;
      btype_q <= {NUM_CH{BTYPE_FIXED}};
      for (int c = 0; c < NUM_CH; c++) begin
        snap_q[c] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      gctrl_q <= gctrl_d;
      chsel_q <= chsel_d;
      en_q    <= en_d;
      rev_q   <= rev_d;
      btype_q <= btype_d;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap[c]) begin
          snap_q[c] <= ch_dbg[c*DBG_WIDTH +: DBG_WIDTH];
        end
      end
    end
  end

  // Per-channel soft-reset timers; hold uses next-state controls so a
  // CTRL/GCTRL write is reflected on ch_rst the cycle after the write
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gzip_ch_rst_pulse #(
      .RST_PULSE_CYCLES(RST_PULSE_CYCLES)
    ) u_pulse (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start[c]),
      .hold_i   (gctrl_d | ~en_d[c]),
      .ch_rst_o (ch_rst[c])
    );
  end

  assign ch_btype         = btype_q;
  assign ch_rev_endianess = rev_q;

endmodule

// File: tb/tb_gzip_ctrl_regs.sv
// Testbench for gzip_ctrl_regs: table-driven directed vectors, hand-written
// pulse/snapshot/pointer sequences and a randomized run, all checked
// against a register-level reference model.
module tb_gzip_ctrl_regs;

  localparam int NUM_CH = 2;
  localparam int DBG_WIDTH = 96;
  localparam int AW = 5;
  localparam int NPULSE = 16;
  localparam int NB = DBG_WIDTH / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gzip_ctrl_regs_if #(.ADDR_WIDTH(AW)) bus();
  logic [NUM_CH-1:0]           ch_busy;
  logic [DBG_WIDTH*NUM_CH-1:0] ch_dbg;
  logic [NUM_CH-1:0]           ch_rst;
  logic [2*NUM_CH-1:0]         ch_btype;
  logic [NUM_CH-1:0]           ch_rev_endianess;

  gzip_ctrl_regs #(
    .NUM_CH(NUM_CH), .DBG_WIDTH(DBG_WIDTH), .ADDR_WIDTH(AW),
    .RST_PULSE_CYCLES(NPULSE), .DEVICE_ID(8'hB9)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .ch_busy(ch_busy), .ch_dbg(ch_dbg),
    .ch_rst(ch_rst), .ch_btype(ch_btype), .ch_rev_endianess(ch_rev_endianess)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int                   m_ptr;
  int                   m_sel;
  bit                   m_gctrl;
  bit                   m_en  [NUM_CH];
  bit                   m_rev [NUM_CH];
  logic [1:0]           m_bt  [NUM_CH];
  int                   m_cnt [NUM_CH];
  bit                   m_rst [NUM_CH];
  logic [DBG_WIDTH-1:0] m_snap[NUM_CH];

  task automatic model_reset();
    m_ptr = 0; m_sel = 0; m_gctrl = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = 0; m_rev[c] = 0; m_bt[c] = 2'b01; m_cnt[c] = 0;
      m_rst[c] = 1; m_snap[c] = '0;
    end
  endtask

  function automatic logic [7:0] m_read(input int a);
    logic [DBG_WIDTH-1:0] t;
    case (a)
      0: return 8'hB9;
      1: return 8'(NUM_CH);
      2: return {7'd0, m_gctrl};
      3: return 8'(m_sel);
      4: return {4'd0, m_rev[m_sel], m_bt[m_sel], m_en[m_sel]};
      6: return {6'd0, ch_busy[m_sel], m_rst[m_sel]};
      default: begin
        if (a >= 8 && a < 8 + NB) begin
          t = m_snap[m_sel] >> (8 * (a - 8));
          return t[7:0];
        end
        return 8'h00;
      end
    endcase
  endfunction

  task automatic model_step(input logic upd, input int addr, input logic rd,
                            input logic wr, input logic [7:0] wd);
    int old_sel;
    bit start[NUM_CH];
    old_sel = m_sel;
    for (int c = 0; c < NUM_CH; c++) start[c] = 0;
`ifdef GZIP_REGS_AUTO_SNAP_EN
    if (upd && addr == 8) m_snap[old_sel] = ch_dbg[old_sel*DBG_WIDTH +: DBG_WIDTH];
`endif
    if (wr) begin
      case (m_ptr)
        2: m_gctrl = wd[0];
        3: if (int'(wd) < NUM_CH) m_sel = int'(wd);
        4: begin
          m_en[old_sel]  = wd[0];
          m_rev[old_sel] = wd[3];
          if (wd[2] == 1'b0) m_bt[old_sel] = wd[2:1];
        end
        5: begin
          if (wd[0]) start[old_sel] = 1;
          if (wd[1]) m_snap[old_sel] = ch_dbg[old_sel*DBG_WIDTH +: DBG_WIDTH];
        end
        default: ;
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (start[c]) m_cnt[c] = NPULSE;
      else if (m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
      m_rst[c] = m_gctrl || !m_en[c] || (m_cnt[c] != 0);
    end
    if (upd) m_ptr = addr;
    else if (rd || wr) m_ptr = (m_ptr + 1) % (1 << AW);
  endtask

  // ---------------- driver ----------------
  // One bus cycle: drive strobes, check the read byte at the falling edge,
  // advance the model, then check registered outputs just after the edge.
  task automatic cyc(input logic upd, input int addr, input logic rd, input logic wr,
                     input logic [7:0] wd, output logic [7:0] seen);
    logic [2*NUM_CH-1:0] e_bt;
    logic [NUM_CH-1:0]   e_rst, e_rev;
    bus.mem_addr_update = upd;
    bus.mem_addr        = AW'(addr);
    bus.mem_rden        = rd;
    bus.mem_wren        = wr;
    bus.mem_wr_data     = wd;
    @(negedge clk);
    exp_q.push_back(m_read(m_ptr));
    seen = bus.mem_rd_data;
    chk("rd_data", bus.mem_rd_data, exp_q.pop_front());
    chk("rd_empty", bus.mem_rd_empty, 1'b0);
    model_step(upd, addr, rd, wr, wd);
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      e_rst[c] = m_rst[c];
      e_rev[c] = m_rev[c];
      e_bt[2*c +: 2] = m_bt[c];
    end
    chk("ch_rst", ch_rst, e_rst);
    chk("ch_btype", ch_btype, e_bt);
    chk("ch_rev", ch_rev_endianess, e_rev);
    bus.mem_addr_update = 0; bus.mem_rden = 0; bus.mem_wren = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.mem_addr_update = 0; bus.mem_rden = 0; bus.mem_wren = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_empty", bus.mem_rd_empty, 1'b1);
      @(posedge clk);
      #1;
      chk("rst_ch_rst", ch_rst, 2'b11);
      chk("rst_ch_btype", ch_btype, 4'b0101);
      chk("rst_ch_rev", ch_rev_endianess, 2'b00);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic measure_pulse(input int ch, output int n);
    logic [7:0] s;
    n = ch_rst[ch] ? 1 : 0;
    for (int i = 0; i < 40 && ch_rst[ch]; i++) begin
      cyc(0, 0, 0, 0, 8'h00, s);
      if (ch_rst[ch]) n++;
    end
  endtask

  task automatic rand_dbg();
    for (int i = 0; i < DBG_WIDTH * NUM_CH / 32; i++) ch_dbg[32*i +: 32] = $urandom;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       upd;
    logic [4:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic [1:0] exp_rst;
    logic [3:0] exp_bt;
    logic [1:0] exp_rev;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [7:0] s;
    int n;
    tbl[0]  = '{1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 8'hB9, 2'b11, 4'b0101, 2'b00};
    tbl[1]  = '{1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 8'hB9, 2'b11, 4'b0101, 2'b00};
    tbl[2]  = '{1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 8'h02, 2'b11, 4'b0101, 2'b00};
    tbl[3]  = '{1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 8'h00, 2'b11, 4'b0101, 2'b00};
    tbl[4]  = '{1'b1, 5'd3, 1'b0, 1'b1, 8'h01, 8'h00, 2'b11, 4'b0101, 2'b00};
    tbl[5]  = '{1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 8'h01, 2'b11, 4'b0101, 2'b00};
    tbl[6]  = '{1'b0, 5'd0, 1'b0, 1'b1, 8'h09, 8'h02, 2'b01, 4'b0001, 2'b10};
    tbl[7]  = '{1'b1, 5'd4, 1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 4'b0001, 2'b10};
    tbl[8]  = '{1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 8'h09, 2'b01, 4'b0001, 2'b10};
    tbl[9]  = '{1'b1, 5'd6, 1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 4'b0001, 2'b10};
    tbl[10] = '{1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 8'h02, 2'b01, 4'b0001, 2'b10};
    tbl[11] = '{1'b1, 5'd4, 1'b0, 1'b1, 8'h0F, 8'h00, 2'b01, 4'b0001, 2'b10};
    tbl[12] = '{1'b0, 5'd0, 1'b0, 1'b1, 8'h0F, 8'h09, 2'b01, 4'b0001, 2'b10};
    tbl[13] = '{1'b1, 5'd4, 1'b1, 1'b0, 8'h00, 8'h00, 2'b01, 4'b0001, 2'b10};
    tbl[14] = '{1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 8'h09, 2'b01, 4'b0001, 2'b10};

    bus.mem_addr = '0; bus.mem_addr_update = 0; bus.mem_rden = 0;
    bus.mem_wren = 0; bus.mem_wr_data = '0;
    ch_busy = 2'b10;
    rand_dbg();
    do_reset(3);

    // Table: reset readout, CTRL write, reserved btype, status
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].upd, int'(tbl[i].addr), tbl[i].rd, tbl[i].wr, tbl[i].wd, s);
      chk($sformatf("tbl%0d_rd", i), s, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_rst", i), ch_rst, tbl[i].exp_rst);
      chk($sformatf("tbl%0d_bt", i), ch_btype, tbl[i].exp_bt);
      chk($sformatf("tbl%0d_rev", i), ch_rev_endianess, tbl[i].exp_rev);
    end

    // Soft reset pulse on channel 1 (pointer sits at CMD)
    cyc(0, 0, 0, 1, 8'h01, s);
    measure_pulse(1, n);
    chk("pulse_len", n, NPULSE);
    // Restart at the 10th high cycle
    cyc(1, 5, 0, 0, 8'h00, s);
    cyc(0, 0, 0, 1, 8'h01, s);
    for (int i = 0; i < 9; i++) begin
      cyc(1, 5, 0, 0, 8'h00, s);
      chk("pulse_hold", ch_rst[1], 1'b1);
    end
    cyc(0, 0, 0, 1, 8'h01, s);
    measure_pulse(1, n);
    chk("pulse_restart_len", n, NPULSE);

    // Snapshot of channel 1, then disturb the debug bus before readout
    rand_dbg();
    for (int b = 0; b < NB; b++) ch_dbg[DBG_WIDTH + 8*b +: 8] = 8'(b);
    cyc(1, 5, 0, 0, 8'h00, s);
    cyc(0, 0, 0, 1, 8'h02, s);
    rand_dbg();
    cyc(0, 0, 1, 0, 8'h00, s);
    cyc(0, 0, 1, 0, 8'h00, s);
    for (int b = 0; b < NB; b++) begin
      cyc(0, 0, 1, 0, 8'h00, s);
      chk($sformatf("snap_b%0d", b), s, 8'(b));
    end

    // Pointer wrap 31 -> 0
    cyc(1, 31, 0, 0, 8'h00, s);
    cyc(0, 0, 1, 0, 8'h00, s);
    chk("wrap_rd31", s, 8'h00);
    cyc(0, 0, 0, 0, 8'h00, s);
    chk("wrap_rd0", s, 8'hB9);

    // Same-cycle read+write at CTRL returns the old value
    cyc(1, 4, 0, 0, 8'h00, s);
    cyc(0, 0, 1, 1, 8'h03, s);
    chk("rdwr_old", s, 8'h09);
    // Same-cycle read+write at CH_SEL advances the pointer once
    cyc(1, 3, 0, 0, 8'h00, s);
    cyc(0, 0, 1, 1, 8'h01, s);
    chk("rdwr_sel", s, 8'h01);
    cyc(0, 0, 0, 0, 8'h00, s);
    chk("rdwr_ptr_once", s, 8'h03);

    // Out-of-range channel select is ignored
    cyc(1, 3, 0, 0, 8'h00, s);
    cyc(0, 0, 0, 1, 8'h05, s);
    cyc(1, 3, 0, 0, 8'h00, s);
    cyc(0, 0, 0, 0, 8'h00, s);
    chk("chsel_ignore", s, 8'h01);

    // Reset mid-pulse
    cyc(1, 5, 0, 0, 8'h00, s);
    cyc(0, 0, 0, 1, 8'h01, s);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00, s);
    do_reset(2);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 8'h00, s);
    chk("post_rst_hold", ch_rst, 2'b11);
    cyc(1, 3, 0, 0, 8'h00, s);
    cyc(0, 0, 0, 1, 8'h01, s);
    cyc(1, 4, 0, 0, 8'h00, s);
    cyc(0, 0, 0, 1, 8'h01, s);
    chk("post_rst_cnt0", ch_rst[1], 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic upd, rd, wr;
      int a;
      rand_dbg();
      ch_busy = NUM_CH'($urandom_range(0, 3));
      upd = ($urandom_range(0, 5) == 0);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 11);
      rd = $urandom_range(0, 1);
      wr = ($urandom_range(0, 2) == 0);
      cyc(upd, a, rd, wr, 8'($urandom_range(0, 255)), s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
